// File: rtl/coax_transaction_sequencer.sv
// Runs one coax command/response transaction: loads a frame into TX, starts it, times the reply, reports a result.
// Optional `COAX_SEQ_RX_FLUSH_EN: pulse rx_reset together with tx_start_strobe to discard stale RX data.
module coax_transaction_sequencer #(
  parameter int RESPONSE_TIMEOUT = 600,
  parameter int TX_STALL_CYCLES  = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] cmd_data,
  input  logic       cmd_valid,
  input  logic       cmd_last,
  output logic       cmd_ready,
  input  logic       abort,
  output logic [9:0] tx_data,
  output logic       tx_load_strobe,
  output logic       tx_start_strobe,
  output logic       tx_reset,
  input  logic       tx_active,
  input  logic       tx_full,
  output logic       rx_reset,
  input  logic       rx_active,
  input  logic       rx_error,
  output logic       busy,
  output logic       done,
  output logic [1:0] result
);

  localparam int CNT_MAX = (RESPONSE_TIMEOUT > TX_STALL_CYCLES) ? RESPONSE_TIMEOUT : TX_STALL_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] RESP_LOAD  = CW'(RESPONSE_TIMEOUT);
  localparam logic [CW-1:0] STALL_LOAD = CW'(TX_STALL_CYCLES);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  localparam logic [1:0] RES_OK       = 2'd0;
  localparam logic [1:0] RES_TIMEOUT  = 2'd1;
  localparam logic [1:0] RES_RX_ERROR = 2'd2;
  localparam logic [1:0] RES_ABORTED  = 2'd3;

  typedef enum logic [2:0] {
    IDLE, LOAD, START, TX_WAIT, RX_WAIT, RX_RECV, DONE
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_dec;
  logic          tx_seen, tx_seen_nxt;
  logic [1:0]    result_nxt;
  logic          accept, abort_hit, flush_q;

  assign cmd_ready = reset_n && ((state == IDLE) || (state == LOAD)) && !tx_full;
  assign accept    = cmd_valid && cmd_ready;
  assign abort_hit = reset_n && abort && (state != IDLE);
  assign cnt_dec   = (cnt != '0) ? (cnt - CNT_ONE) : cnt;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign tx_reset  = abort_hit;
  assign rx_reset  = abort_hit || flush_q;

  // Timeouts leave the wait state on the same edge the counter steps to zero.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    tx_seen_nxt = tx_seen;
    result_nxt  = result;
    case (state)
      IDLE: if (accept) state_nxt = cmd_last ? START : LOAD;
      LOAD: if (accept && cmd_last) state_nxt = START;
      START: begin
        cnt_nxt     = STALL_LOAD;
        tx_seen_nxt = 1'b0;
        state_nxt   = TX_WAIT;
      end
      TX_WAIT: begin
        if (!tx_seen) begin
          if (tx_active) begin
            tx_seen_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt_dec;
            if (cnt <= CNT_ONE) begin
              state_nxt  = DONE;
              result_nxt = RES_TIMEOUT;
            end
          end
        end else if (!tx_active) begin
          cnt_nxt   = RESP_LOAD;
          state_nxt = RX_WAIT;
        end
      end
      RX_WAIT: begin
        if (rx_error) begin
          state_nxt  = DONE;
          result_nxt = RES_RX_ERROR;
        end else if (rx_active) begin
          state_nxt = RX_RECV;
        end else begin
          cnt_nxt = cnt_dec;
          if (cnt <= CNT_ONE) begin
            state_nxt  = DONE;
            result_nxt = RES_TIMEOUT;
          end
        end
      end
      RX_RECV: begin
        if (rx_error) begin
          state_nxt  = DONE;
          result_nxt = RES_RX_ERROR;
        end else if (!rx_active) begin
          state_nxt  = DONE;
          result_nxt = RES_OK;
        end
      end
      DONE: begin
        tx_seen_nxt = 1'b0;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort_hit) begin
      state_nxt  = DONE;
      result_nxt = RES_ABORTED;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= IDLE;
      cnt             <= '0;
      tx_seen         <= 1'b0;
      result          <= RES_OK;
      tx_data         <= '0;
      tx_load_strobe  <= 1'b0;
      tx_start_strobe <= 1'b0;
      flush_q         <= 1'b0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      tx_seen         <= tx_seen_nxt;
      result          <= result_nxt;
      tx_load_strobe  <= accept;
      if (accept) tx_data <= cmd_data;
      // Registered so the start follows the final load strobe by one cycle.
      tx_start_strobe <= (state == START) && !abort_hit;
`ifdef COAX_SEQ_RX_FLUSH_EN
      flush_q         <= (state == START) && !abort_hit;
`else
      flush_q         <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_coax_transaction_sequencer.sv
// Bench for coax_transaction_sequencer: scenario table plus hand-written backpressure/abort/reset sequences.
module tb_coax_transaction_sequencer;

  localparam int RESP  = 600;
  localparam int STALL = 64;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] cmd_data = '0;
  logic       cmd_valid = 1'b0, cmd_last = 1'b0, abort = 1'b0;
  logic       tx_active = 1'b0, tx_full = 1'b0, rx_active = 1'b0, rx_error = 1'b0;
  logic       cmd_ready, tx_load_strobe, tx_start_strobe, tx_reset, rx_reset, busy, done;
  logic [9:0] tx_data;
  logic [1:0] result;

  coax_transaction_sequencer #(.RESPONSE_TIMEOUT(RESP), .TX_STALL_CYCLES(STALL)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_last(cmd_last),
    .cmd_ready(cmd_ready), .abort(abort), .tx_data(tx_data), .tx_load_strobe(tx_load_strobe),
    .tx_start_strobe(tx_start_strobe), .tx_reset(tx_reset), .tx_active(tx_active), .tx_full(tx_full),
    .rx_reset(rx_reset), .rx_active(rx_active), .rx_error(rx_error), .busy(busy), .done(done),
    .result(result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct { logic [9:0] data; int cyc; } ld_t;
  ld_t        load_q[$];
  logic [1:0] res_q[$];
  int load_cnt = 0, done_cnt = 0, done_cyc = 0, rst_cnt = 0;
  int last_load_cyc = 0, start_cyc = 0;
  logic done_prev = 1'b0;

  // Negedge monitor: scoreboard for load strobes and results, timing of start strobe.
  always @(negedge clk) begin
    ld_t e;
    if (reset_n) begin
      if (tx_load_strobe) begin
        load_cnt++;
        last_load_cyc = cyc;
        if (load_q.size() == 0) check("unexpected_load", load_cnt, 0);
        else begin
          e = load_q.pop_front();
          check("load_data", tx_data, e.data);
          check("load_cycle", cyc, e.cyc);
        end
      end
      if (cmd_valid && cmd_ready) load_q.push_back('{cmd_data, cyc + 1});
      if (tx_start_strobe) begin
        start_cyc = cyc;
        check("start_after_load", cyc, last_load_cyc + 1);
`ifdef COAX_SEQ_RX_FLUSH_EN
        check("flush_with_start", rx_reset, 1'b1);
`else
        check("no_rx_reset_at_start", rx_reset, 1'b0);
`endif
      end
      if (tx_reset) rst_cnt++;
      if (rx_reset !== tx_reset && !tx_start_strobe) check("rx_reset_pairing", rx_reset, tx_reset);
      if (done_prev) check("busy_after_done", busy, 1'b0);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (res_q.size() == 0) check("unexpected_done", done_cnt, 0);
        else check("result", result, res_q.pop_front());
      end
    end
    done_prev = done;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_word(input logic [9:0] d, input logic l);
    bit ok;
    ok = 1'b0;
    cmd_valid = 1'b1; cmd_data = d; cmd_last = l;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk); ok = cmd_ready;
      tick();
    end
    cmd_valid = 1'b0; cmd_last = 1'b0;
    if (!ok) check("send_accept", ok, 1'b1);
  endtask

  task automatic wait_done(input int budget, output int dcyc);
    int d0;
    d0 = done_cnt;
    dcyc = -1;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt != d0) break;
      tick();
    end
    if (done_cnt != d0) dcyc = done_cyc;
    else check("done_timeout", done_cnt, d0 + 1);
  endtask

  typedef enum int { SC_OK, SC_NORESP, SC_RXERR, SC_RXERR_SIM, SC_ABORT_RXW, SC_STALL } scen_t;
  typedef struct { logic [9:0] data; scen_t scen; logic [1:0] exp_res; } vec_t;
  vec_t vecs[6];

  // One single-word transaction; checks completion timing relative to the stimulus edge.
  task automatic run_txn(input vec_t v);
    int fall, e, dcyc, r0;
    res_q.push_back(v.exp_res);
    send_word(v.data, 1'b1);
    tick();
    if (v.scen == SC_STALL) begin
      wait_done(STALL + 20, dcyc);
      check("stall_timing", dcyc, start_cyc + STALL);
    end else begin
      tx_active = 1'b1;
      repeat (200) tick();
      tx_active = 1'b0;
      fall = cyc;
      case (v.scen)
        SC_NORESP: begin
          wait_done(RESP + 50, dcyc);
          check("resp_timeout_timing", dcyc, fall + RESP + 1);
        end
        SC_OK: begin
          repeat (50) tick();
          rx_active = 1'b1;
          repeat (40) tick();
          rx_active = 1'b0;
          e = cyc;
          wait_done(20, dcyc);
          check("ok_timing", dcyc, e + 1);
        end
        SC_RXERR: begin
          repeat (50) tick();
          rx_active = 1'b1;
          tick();
          repeat (10) tick();
          rx_error = 1'b1;
          e = cyc;
          wait_done(20, dcyc);
          check("rxerr_timing", dcyc, e + 1);
        end
        SC_RXERR_SIM: begin
          repeat (50) tick();
          rx_active = 1'b1;
          rx_error = 1'b1;
          e = cyc;
          wait_done(20, dcyc);
          check("rxerr_priority_timing", dcyc, e + 1);
        end
        default: begin
          repeat (20) tick();
          r0 = rst_cnt;
          abort = 1'b1;
          e = cyc;
          @(negedge clk);
          check("abort_tx_reset", tx_reset, 1'b1);
          check("abort_rx_reset", rx_reset, 1'b1);
          tick();
          abort = 1'b0;
          @(negedge clk);
          check("abort_reset_width", rst_cnt - r0, 1);
          wait_done(20, dcyc);
          check("abort_timing", dcyc, e + 1);
        end
      endcase
    end
    rx_active = 1'b0;
    rx_error = 1'b0;
    repeat (3) tick();
    check("result_hold", result, v.exp_res);
    check("idle_ready", cmd_ready, 1'b1);
  endtask

  initial begin
    int d0, r0, lc0, dcyc;
    vecs[0] = '{10'h002, SC_OK,        2'd0};
    vecs[1] = '{10'h002, SC_NORESP,    2'd1};
    vecs[2] = '{10'h205, SC_RXERR,     2'd2};
    vecs[3] = '{10'h13c, SC_RXERR_SIM, 2'd2};
    vecs[4] = '{10'h3a1, SC_ABORT_RXW, 2'd3};
    vecs[5] = '{10'h0ff, SC_STALL,     2'd1};

    // Reset state with abort and a pending word asserted.
    abort = 1'b1; cmd_valid = 1'b1; cmd_data = 10'h155; cmd_last = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result, 2'd0);
    check("rst_tx_reset", tx_reset, 1'b0);
    check("rst_rx_reset", rx_reset, 1'b0);
    check("rst_strobes", {tx_load_strobe, tx_start_strobe}, 2'b00);
    check("rst_tx_data", tx_data, 10'h000);
    abort = 1'b0; cmd_valid = 1'b0; cmd_last = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (2) tick();

    // Abort while idle is ignored.
    d0 = done_cnt;
    abort = 1'b1;
    @(negedge clk);
    check("idle_abort_tx_reset", tx_reset, 1'b0);
    tick();
    abort = 1'b0;
    repeat (2) tick();
    check("idle_abort_busy", busy, 1'b0);
    check("idle_abort_no_done", done_cnt, d0);

    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    // Four-word frame with tx_full held mid-frame; ends in a TX stall timeout.
    lc0 = load_cnt;
    res_q.push_back(2'd1);
    send_word(10'h155, 1'b0);
    send_word(10'h0aa, 1'b0);
    tx_full = 1'b1; cmd_valid = 1'b1; cmd_data = 10'h3ff;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_ready_low", cmd_ready, 1'b0);
      tick();
    end
    tx_full = 1'b0;
    send_word(10'h3ff, 1'b0);
    send_word(10'h201, 1'b1);
    repeat (4) tick();
    cmd_valid = 1'b1; cmd_data = 10'h077; cmd_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("busy_ready_low", cmd_ready, 1'b0);
      tick();
    end
    cmd_valid = 1'b0; cmd_last = 1'b0;
    wait_done(STALL + 20, dcyc);
    check("bp_stall_timing", dcyc, start_cyc + STALL);
    check("bp_load_count", load_cnt - lc0, 4);
    repeat (3) tick();

    // Reset mid-transaction: no done, no buffer resets, result cleared.
    send_word(10'h0f0, 1'b1);
    repeat (5) tick();
    d0 = done_cnt;
    r0 = rst_cnt;
    check("mid_busy", busy, 1'b1);
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_rst_tx_reset", tx_reset, 1'b0);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    check("mid_rst_no_done", done_cnt, d0);
    check("mid_rst_no_reset_pulse", rst_cnt, r0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_result", result, 2'd0);

    check("result_queue_empty", res_q.size(), 0);
    check("load_queue_empty", load_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", passed, checks);
    $fatal(1, "watchdog");
  end

endmodule
